// File: rtl/ram_loader.sv
// ram_loader: streams bytes from a valid/ready source into the SAP-U program RAM.
// Writes go to consecutive addresses starting at 0. Each byte is written
// with an accept / setup / strobe / hold sequence. An optional readback pass then
// sums the RAM contents and compares the result with the sum of the bytes loaded.
//
// Ports:
//   clk, clear_n      clock (rising edge), async active-low reset
//   start, length     begin a load of `length` bytes (0 = none, clamps to depth)
//   in_data/in_valid/in_ready   byte stream handshake
//   ram_rdata         RAM read data for the readback pass
//   prog_mode         RAM input-path select (PROG_SEL while loading)
//   dipswitch_addr/dipswitch_data/write_enable/output_enable   RAM bus
//   busy, done, error status: busy outside IDLE, done 1-cycle pulse, sticky error
module ram_loader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WE_CYCLES  = 1,
    parameter bit          VERIFY     = 1'b1,
    parameter bit          PROG_SEL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  prog_mode,
    output logic [ADDR_WIDTH-1:0] dipswitch_addr,
    output logic [DATA_WIDTH-1:0] dipswitch_data,
    output logic                  write_enable,
    output logic                  output_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int unsigned         WE_W    = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [WE_W-1:0]     WE_LAST = WE_W'(WE_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_WAIT, SETUP, WRITE, HOLD,
        RD_SETUP, RD_SAMPLE, CHECK, FINISH, FINISH_ERR
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [WE_W-1:0]       we_cnt;
    logic [DATA_WIDTH-1:0] wsum;
    logic [DATA_WIDTH-1:0] rsum;

    // Outputs are assigned together with the state they belong to, so each one
    // is a register that already reflects the state being entered.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state          <= IDLE;
            in_ready       <= 1'b0;
            write_enable   <= 1'b0;
            output_enable  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            prog_mode      <= ~PROG_SEL;
            dipswitch_addr <= '0;
            dipswitch_data <= '0;
            count          <= '0;
            last_idx       <= '0;
            we_cnt         <= '0;
            wsum           <= '0;
            rsum           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            // Oversized lengths load the whole RAM, never wrap.
                            last_idx       <= (length >= DEPTH) ? '1
                                                                : ADDR_WIDTH'(length - 1'b1);
                            error          <= 1'b0;
                            wsum           <= '0;
                            rsum           <= '0;
                            count          <= '0;
                            dipswitch_addr <= '0;
                            prog_mode      <= PROG_SEL;
                            busy           <= 1'b1;
                            in_ready       <= 1'b1;
                            state          <= LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (in_valid) begin
                        dipswitch_data <= in_data;
                        wsum           <= wsum + in_data;
                        in_ready       <= 1'b0;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    write_enable <= 1'b1;
                    we_cnt       <= '0;
                    state        <= WRITE;
                end
                WRITE: begin
                    if (we_cnt == WE_LAST) begin
                        write_enable <= 1'b0;
                        state        <= HOLD;
                    end else begin
                        we_cnt <= we_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (count == last_idx) begin
                        if (VERIFY) begin
                            dipswitch_addr <= '0;
                            output_enable  <= 1'b1;
                            state          <= RD_SETUP;
                        end else begin
                            done      <= 1'b1;
                            prog_mode <= ~PROG_SEL;
                            state     <= FINISH;
                        end
                    end else begin
                        dipswitch_addr <= dipswitch_addr + 1'b1;
                        count          <= count + 1'b1;
                        in_ready       <= 1'b1;
                        state          <= LOAD_WAIT;
                    end
                end
                RD_SETUP: begin
                    state <= RD_SAMPLE;
                end
                RD_SAMPLE: begin
                    rsum <= rsum + ram_rdata;
                    if (dipswitch_addr == last_idx) begin
                        output_enable <= 1'b0;
                        state         <= CHECK;
                    end else begin
                        dipswitch_addr <= dipswitch_addr + 1'b1;
                        state          <= RD_SETUP;
                    end
                end
                CHECK: begin
                    prog_mode <= ~PROG_SEL;
                    if (rsum == wsum) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        error <= 1'b1;
                        state <= FINISH_ERR;
                    end
                end
                FINISH, FINISH_ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    in_ready      <= 1'b0;
                    write_enable  <= 1'b0;
                    output_enable <= 1'b0;
                    busy          <= 1'b0;
                    prog_mode     <= ~PROG_SEL;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
